// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported unified memory between the fetch
//               frontend and the load/store stage. Each access is issued,
//               waits LATENCY cycles, then returns its response. Data wins
//               arbitration unless a pending fetch has lost STARVE_MAX
//               issue decisions in a row. Optional performance counters are
//               built when the ARB_PERF_EN macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int LATENCY    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_grant,
   output logic        i_valid,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic        d_grant,
   output logic        d_valid,
   output logic [31:0] d_rdata,
   output logic        m_en,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_be,
   input  logic [31:0] m_rdata,
   output logic        stall_f
`ifdef ARB_PERF_EN
   ,
   output logic [31:0] perf_i_grants,
   output logic [31:0] perf_d_grants,
   output logic [31:0] perf_conflicts
`endif
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BUSY_I = 2'd1,
      S_BUSY_D = 2'd2
   } state_t;

   localparam logic [2:0] C_WAIT_INIT  = 3'(LATENCY - 1);
   localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

   state_t     r_state,  w_state_nxt;
   logic [2:0] r_wait,   w_wait_nxt;
   logic [3:0] r_starve, w_starve_nxt;
   logic       r_store,  w_store_nxt;

   logic w_complete;
   logic w_slot;
   logic w_pick_d;
   logic w_pick_i;

   // A busy access completes when its wait count has run down; that cycle
   // doubles as an issue slot so back-to-back accesses lose no cycle.
   assign w_complete = (r_state != S_IDLE) && (r_wait == 3'd0);
   assign w_slot     = (r_state == S_IDLE) || w_complete;
   // Data has priority unless the fetch side has been starved long enough.
   assign w_pick_d   = w_slot && d_req && ((r_starve < C_STARVE_MAX) || !i_req);
   assign w_pick_i   = w_slot && i_req && !w_pick_d;

   // State, wait and starve registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_wait   <= 3'd0;
         r_starve <= 4'd0;
         r_store  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_wait   <= w_wait_nxt;
         r_starve <= w_starve_nxt;
         r_store  <= w_store_nxt;
      end
   end

   // Next-state and output decode: completion, issue, starvation tracking.
   always_comb begin
      w_state_nxt  = r_state;
      w_wait_nxt   = r_wait;
      w_starve_nxt = r_starve;
      w_store_nxt  = r_store;
      i_grant      = 1'b0;
      i_valid      = 1'b0;
      i_rdata      = 32'd0;
      d_grant      = 1'b0;
      d_valid      = 1'b0;
      d_rdata      = 32'd0;
      m_en         = 1'b0;
      m_we         = 1'b0;
      m_addr       = 32'd0;
      m_wdata      = 32'd0;
      m_be         = 4'd0;

      if ((r_state != S_IDLE) && (r_wait != 3'd0)) begin
         w_wait_nxt = r_wait - 3'd1;
      end

      if (w_complete) begin
         w_state_nxt = S_IDLE;
         if (r_state == S_BUSY_I) begin
            i_valid = 1'b1;
            i_rdata = m_rdata;
         end else begin
            d_valid = 1'b1;
            d_rdata = r_store ? 32'd0 : m_rdata;
         end
      end

      if (w_pick_d) begin
         d_grant     = 1'b1;
         m_en        = 1'b1;
         m_we        = d_we;
         m_addr      = d_addr;
         m_wdata     = d_wdata;
         m_be        = d_we ? d_be : 4'hF;
         w_state_nxt = S_BUSY_D;
         w_wait_nxt  = C_WAIT_INIT;
         w_store_nxt = d_we;
      end else if (w_pick_i) begin
         i_grant     = 1'b1;
         m_en        = 1'b1;
         m_addr      = i_addr;
         m_be        = 4'hF;
         w_state_nxt = S_BUSY_I;
         w_wait_nxt  = C_WAIT_INIT;
         w_store_nxt = 1'b0;
      end

      if (!i_req || w_pick_i) begin
         w_starve_nxt = 4'd0;
      end else if (w_pick_d && (r_starve < C_STARVE_MAX)) begin
         w_starve_nxt = r_starve + 4'd1;
      end

      // While reset is held nothing is granted and any in-flight response
      // is dropped; the frontend stall still mirrors its request.
      if (reset) begin
         i_grant = 1'b0;
         i_valid = 1'b0;
         i_rdata = 32'd0;
         d_grant = 1'b0;
         d_valid = 1'b0;
         d_rdata = 32'd0;
         m_en    = 1'b0;
         m_we    = 1'b0;
         m_addr  = 32'd0;
         m_wdata = 32'd0;
         m_be    = 4'd0;
      end

      stall_f = i_req && !i_valid;
   end

`ifdef ARB_PERF_EN
   // Grant and conflict counters; wrap naturally at 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_i_grants  <= 32'd0;
         perf_d_grants  <= 32'd0;
         perf_conflicts <= 32'd0;
      end else begin
         if (i_grant) perf_i_grants <= perf_i_grants + 32'd1;
         if (d_grant) perf_d_grants <= perf_d_grants + 32'd1;
         if (w_slot && i_req && d_req) perf_conflicts <= perf_conflicts + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter: directed scenarios
//               followed by randomized traffic, all compared cycle by cycle
//               against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam int LAT  = 3;
   localparam int SMAX = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, i_grant, i_valid;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_we, d_grant, d_valid;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_be;
   logic        m_en, m_we;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_be;
   logic        stall_f;
`ifdef ARB_PERF_EN
   logic [31:0] perf_i_grants, perf_d_grants, perf_conflicts;
`endif

   always #5 clk = ~clk;

   mem_port_arbiter #(.LATENCY(LAT), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_valid(i_valid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_grant(d_grant), .d_valid(d_valid), .d_rdata(d_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
      .m_rdata(m_rdata), .stall_f(stall_f)
`ifdef ARB_PERF_EN
      , .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
      .perf_conflicts(perf_conflicts)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: an access occupies the port from its issue cycle
   // until issue cycle + LAT, when its response appears.
   int cyc = 0;
   bit mdl_busy = 0;
   bit mdl_own_d = 0;
   bit mdl_store = 0;
   int mdl_done = 0;
   int mdl_starve = 0;
   int mdl_pi = 0, mdl_pd = 0, mdl_pc = 0;
   bit e_gi, e_gd;

   // Observed DUT outputs of the most recent step, for directed checks.
   logic        obs_ig, obs_dg, obs_iv, obs_dv, obs_stall;
   logic [31:0] obs_irdata, obs_drdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: inputs are already driven; compare, then advance.
   task automatic step();
      bit comp, slot, ev_i, ev_d;
      #3;
      comp = !reset && mdl_busy && (cyc == mdl_done);
      slot = !reset && (!mdl_busy || comp);
      e_gd = slot && d_req && ((mdl_starve < SMAX) || !i_req);
      e_gi = slot && i_req && !e_gd;
      ev_i = comp && !mdl_own_d;
      ev_d = comp && mdl_own_d;

      obs_ig = i_grant; obs_dg = d_grant; obs_iv = i_valid; obs_dv = d_valid;
      obs_stall = stall_f; obs_irdata = i_rdata; obs_drdata = d_rdata;

      check("i_grant", i_grant, e_gi);
      check("d_grant", d_grant, e_gd);
      check("i_valid", i_valid, ev_i);
      check("d_valid", d_valid, ev_d);
      check("i_rdata", i_rdata, ev_i ? m_rdata : 32'd0);
      check("d_rdata", d_rdata, (ev_d && !mdl_store) ? m_rdata : 32'd0);
      check("m_en", m_en, e_gi || e_gd);
      check("m_we", m_we, e_gd && d_we);
      check("stall_f", stall_f, i_req && !ev_i);
      if (e_gi || e_gd) begin
         check("m_addr", m_addr, e_gd ? d_addr : i_addr);
         check("m_be", m_be, (e_gd && d_we) ? d_be : 4'hF);
      end
      if (e_gd && d_we) check("m_wdata", m_wdata, d_wdata);

      @(posedge clk);
      if (reset) begin
         mdl_busy = 0; mdl_starve = 0;
         mdl_pi = 0; mdl_pd = 0; mdl_pc = 0;
      end else begin
         if (comp) mdl_busy = 0;
         if (e_gi || e_gd) begin
            mdl_busy = 1; mdl_own_d = e_gd; mdl_store = e_gd && d_we;
            mdl_done = cyc + LAT;
         end
         if (slot && i_req && d_req) mdl_pc++;
         if (e_gi) mdl_pi++;
         if (e_gd) mdl_pd++;
         if (!i_req || e_gi) mdl_starve = 0;
         else if (e_gd && mdl_starve < SMAX) mdl_starve++;
      end
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      int nd;
      bit got;
      reset = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0;
      d_addr = 0; d_wdata = 0; d_be = 0; m_rdata = 32'h24080005;
      @(posedge clk); #1;

      // Reset state; stall_f follows i_req even in reset.
      step();
      check("rst_stall_lo", obs_stall, 1'b0);
      i_req = 1; i_addr = 32'h100;
      step();
      check("rst_stall_hi", obs_stall, 1'b1);
      check("rst_no_grant", obs_ig, 1'b0);
      reset = 0;

      // Fetch only.
      step();
      check("t1_grant", obs_ig, 1'b1);
      check("t1_stall", obs_stall, 1'b1);
      i_req = 0;
      repeat (LAT - 1) step();
      step();
      check("t1_valid", obs_iv, 1'b1);
      check("t1_rdata", obs_irdata, 32'h24080005);
      check("t1_stall_after", obs_stall, 1'b0);
      step();

      // Simultaneous fetch and load: data first, fetch in its completion slot.
      i_req = 1; i_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h1000;
      m_rdata = 32'hCAFE0001;
      step();
      check("t2_dgrant", obs_dg, 1'b1);
      check("t2_no_igrant", obs_ig, 1'b0);
      d_req = 0;
      repeat (LAT - 1) step();
      step();
      check("t2_dvalid", obs_dv, 1'b1);
      check("t2_igrant", obs_ig, 1'b1);
      i_req = 0;
      repeat (LAT - 1) step();
      step();
      check("t2_ivalid", obs_iv, 1'b1);

      // Store: byte enables pass through, acknowledge carries zero data.
      d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
      m_rdata = 32'h55AA55AA;
      step();
      check("t3_dgrant", obs_dg, 1'b1);
      d_req = 0; d_we = 0;
      repeat (LAT - 1) step();
      step();
      check("t3_dvalid", obs_dv, 1'b1);
      check("t3_drdata", obs_drdata, 32'd0);

      // Starvation: with data held, fetch wins every (SMAX+1)th slot, twice
      // in a row to show the guard count restarts after a fetch grant.
      do_reset();
      for (int r = 0; r < 2; r++) begin
         i_req = 1; i_addr = 32'h500 + 32'(r * 4); d_req = 1; d_we = 0; d_addr = 32'h2000;
         nd = 0; got = 0;
         for (int k = 0; k < 60 && !got; k++) begin
            step();
            if (obs_dg) begin nd++; d_addr = d_addr + 32'd4; end
            if (obs_ig) got = 1;
         end
         check("t4_fetch_won", got, 1'b1);
         check("t4_data_wins", nd, SMAX);
      end
      i_req = 0; d_req = 0;
      repeat (LAT + 1) step();

      // Reset while a fetch is waiting: response dropped, new fetch granted
      // in the first cycle out of reset.
      i_req = 1; i_addr = 32'h300; m_rdata = 32'h12345678;
      step();
      check("t5_grant", obs_ig, 1'b1);
      i_req = 0;
      step();
      reset = 1;
      step();
      check("t5_no_valid_rst", obs_iv, 1'b0);
      reset = 0; i_req = 1; i_addr = 32'h304;
      step();
      check("t5_regrant", obs_ig, 1'b1);
      check("t5_no_valid", obs_iv, 1'b0);
      i_req = 0;
      repeat (LAT + 1) step();

`ifdef ARB_PERF_EN
      // Three fetches, two loads, one overlapping decision.
      do_reset();
      i_req = 1; i_addr = 32'h10; step(); i_req = 0; repeat (LAT) step();
      i_req = 1; i_addr = 32'h14; d_req = 1; d_we = 0; d_addr = 32'h80;
      step(); d_req = 0;
      repeat (LAT - 1) step();
      step(); i_req = 0;
      repeat (LAT) step();
      i_req = 1; i_addr = 32'h18; step(); i_req = 0; repeat (LAT) step();
      d_req = 1; d_addr = 32'h84; step(); d_req = 0; repeat (LAT) step();
      check("perf_i", perf_i_grants, 32'd3);
      check("perf_d", perf_d_grants, 32'd2);
      check("perf_c", perf_conflicts, 32'd1);
`endif

      // Randomized traffic honouring the hold-until-grant protocol.
      for (int k = 0; k < 800; k++) begin
         m_rdata = $urandom;
         reset = ($urandom_range(99) == 0);
         if (!i_req && $urandom_range(2) == 0) begin
            i_req = 1; i_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (!d_req && $urandom_range(2) == 0) begin
            d_req = 1; d_we = $urandom_range(1);
            d_addr = $urandom & 32'hFFFF_FFFC; d_wdata = $urandom;
            d_be = 4'($urandom_range(15));
         end
         step();
         if (e_gi) i_req = 0;
         if (e_gd) d_req = 0;
`ifdef ARB_PERF_EN
         check("perf_i_rnd", perf_i_grants, mdl_pi);
         check("perf_d_rnd", perf_d_grants, mdl_pd);
         check("perf_c_rnd", perf_conflicts, mdl_pc);
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between the instruction-fetch frontend and the load/store stage. Sequences each access as issue → wait LATENCY cycles → response. Gives data accesses priority, with a starvation guard so fetch always progresses. Drives the frontend stall so fetch-side buffering holds while the port is taken.

Parameters:
LATENCY, 1, memory read latency in cycles from m_en issue to m_rdata valid (range 1..7)
STARVE_MAX, 4, consecutive lost arbitration cycles after which a pending fetch wins over a data request (range 1..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
i_req  in  1  fetch request; held high with stable i_addr until i_grant
i_addr  in  32  fetch byte address (word aligned)
i_grant  out  1  fetch access issued this cycle
i_valid  out  1  one-cycle pulse: i_rdata valid
i_rdata  out  32  fetched instruction word
d_req  in  1  load/store request; held with stable d_* until d_grant
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data byte address (word aligned)
d_wdata  in  32  store data
d_be  in  4  store byte enables
d_grant  out  1  data access issued this cycle
d_valid  out  1  one-cycle pulse: load data valid / store acknowledged
d_rdata  out  32  load data; 0 on store acknowledge
m_en  out  1  memory access strobe
m_we  out  1  memory write enable
m_addr  out  32  memory address
m_wdata  out  32  memory write data
m_be  out  4  memory byte enables (4'hF for fetch and loads)
m_rdata  in  32  memory read data, valid LATENCY cycles after m_en
stall_f  out  1  i_req & ~i_valid; frontend must hold state while high

Behaviour:
- Reset: state IDLE, wait counter 0, starve counter 0. All outputs 0 except stall_f, which follows i_req combinationally.
- States: IDLE, BUSY_I, BUSY_D.
- Issue decision (combinational) in IDLE, and in the completing cycle of BUSY_x:
  - data wins if d_req and starve < STARVE_MAX;
  - else fetch wins if i_req;
  - else data wins if d_req.
- Issue outputs:
  - winner's grant = 1; m_en = 1; m_addr, m_we, m_wdata, m_be driven from the winner.
  - Fetch forces m_we = 0 and m_be = 4'hF. Loads also use m_be = 4'hF.
  - Next state is BUSY_I or BUSY_D; wait counter loads LATENCY-1.
- BUSY_x:
  - While wait > 0: decrement; m_en = 0; no grants.
  - When wait == 0 (completing cycle): x_valid = 1 and x_rdata = m_rdata (d_rdata = 0 for stores).
  - The same cycle may issue the next access, so back-to-back throughput is one access per LATENCY cycles.
  - If nothing is issued, next state is IDLE.
- Starve counter:
  - increments (saturating at STARVE_MAX) each issue-decision cycle where i_req = 1 and data wins;
  - clears when fetch is granted or i_req = 0.
- Simultaneous requests, no starvation: data first, fetch next slot.
- A request deasserted before grant is a protocol error; behaviour is unspecified.
- Grants and valids are never asserted in the same cycle for different requesters, except a completing valid plus a new grant.
- Reset mid-access: in-flight response discarded, no valid pulse, next cycle IDLE.
- Stores complete with d_valid at the same point as loads (uniform latency).

Optional Feature:
ARB_PERF_EN:
- Defined: adds outputs perf_i_grants[31:0], perf_d_grants[31:0], perf_conflicts[31:0].
  - perf_i_grants / perf_d_grants count grants of each requester.
  - perf_conflicts counts issue-decision cycles with i_req & d_req both high.
  - All wrap modulo 2^32 and clear on reset.
- Undefined: the ports are absent and no counters are built.

Test Plan:
- LATENCY=1, fetch only, i_addr=0x100 held, m_rdata=0x24080005 → i_grant cycle N, i_valid cycle N+1 with i_rdata=0x24080005; stall_f high in cycle N only.
- Simultaneous i_req (0x200) and d_req load (0x1000) → d_grant first, d_valid next cycle; i_grant in that same cycle; i_valid one cycle later.
- STARVE_MAX=4, d_req held high continuously with i_req high → data granted 4 times, 5th issue slot grants fetch, starve counter back to 0.
- Store d_addr=0x40, d_wdata=0xDEADBEEF, d_be=4'b0011 → m_we=1, m_be=4'b0011, m_wdata=0xDEADBEEF; d_valid next cycle with d_rdata=0.
- LATENCY=3, fetch issued, reset asserted at wait=1 → no i_valid, state IDLE; a new i_req is granted the cycle after reset deasserts.
- ARB_PERF_EN defined: 3 fetches, 2 loads, 1 overlapping cycle → perf_i_grants=3, perf_d_grants=2, perf_conflicts=1.
